// File: rtl/info_console.sv
// Status-stream text console: buffers {attr, byte} words and renders each as two
// hex-digit character cells through a text-VRAM write port at a self-advancing cursor.
module info_console #(
  parameter int COLS       = 64,
  parameter int ROWS       = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [15:0]                            info,
  input  logic                                   info_e,
  output logic                                   vram_we,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   vram_waddr,
  output logic [15:0]                            vram_wdata,
  output logic                                   busy,
  output logic                                   overflow
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;
  localparam int FW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HI, LO, CLEAR} state_t;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // ---------------- input FIFO ----------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr, wr_ptr;
  logic [FW:0]   count, count_n;
  logic          fifo_full, fifo_empty, push, pop;
  logic [15:0]   head;

  assign fifo_full  = (count == (FW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  // A full FIFO still accepts a push when the same cycle pops.
  assign push       = info_e && (!fifo_full || pop);

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + (FW+1)'(1);
    else if (!push && pop) count_n = count - (FW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= info;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FW'(1);
      if (pop)  rd_ptr <= rd_ptr + FW'(1);
      count <= count_n;
      if (info_e && !push) overflow <= 1'b1;
    end
  end

  // ---------------- render FSM ----------------
  // HI/LO name the digit presented on the write port during that state; the
  // write is registered in the cycle that decides it, so decode happens in
  // IDLE and LO and outputs stay bubble-free across back-to-back words.
  state_t        state, state_n;
  logic [AW-1:0] cur, cur_n, clr, clr_n;
  logic [15:0]   word, word_n;
  logic          we_n;
  logic [AW-1:0] addr_n;
  logic [15:0]   data_n;
  logic [RW-1:0] row;

  assign row = cur[AW-1:CW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      clr        <= '0;
      word       <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      clr        <= clr_n;
      word       <= word_n;
      vram_we    <= we_n;
      vram_waddr <= addr_n;
      vram_wdata <= data_n;
      busy       <= (state_n != IDLE) || (count_n != '0);
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    clr_n   = clr;
    word_n  = word;
    we_n    = 1'b0;
    addr_n  = vram_waddr;
    data_n  = vram_wdata;
    pop     = 1'b0;
    unique case (state)
      IDLE, LO: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[15:8] != 8'h00) begin
            word_n  = head;
            we_n    = 1'b1;
            addr_n  = cur;
            data_n  = {head[15:8], hex(head[7:4])};
            cur_n   = cur + AW'(1);
            state_n = HI;
          end else if (head[7:0] == 8'h0A) begin
            cur_n   = {row + RW'(1), {CW{1'b0}}};
            state_n = IDLE;
          end else if (head[7:0] == 8'h0C) begin
            we_n    = 1'b1;
            addr_n  = '0;
            data_n  = 16'h0020;
            clr_n   = AW'(1);
            state_n = CLEAR;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      HI: begin
        we_n    = 1'b1;
        addr_n  = cur;
        data_n  = {word[15:8], hex(word[3:0])};
        cur_n   = cur + AW'(1);
        state_n = LO;
      end
      CLEAR: begin
        // clr wraps back to 0 once the last cell has been issued.
        if (clr == '0) begin
          cur_n   = '0;
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = clr;
          data_n = 16'h0020;
          clr_n  = clr + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_info_console.sv
// Directed bench for info_console on a 4x2 screen with a 4-entry FIFO.
module tb_info_console;
  localparam int COLS = 4, ROWS = 2, DEPTH = 4;
  localparam int AW = 3;

  logic          clk = 1'b0, reset = 1'b1, info_e = 1'b0;
  logic [15:0]   info = '0;
  logic          vram_we, busy, overflow;
  logic [AW-1:0] vram_waddr;
  logic [15:0]   vram_wdata;

  info_console #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .info(info), .info_e(info_e),
    .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // write log sampled mid-cycle
  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];
  int            wc[$];
  always @(negedge clk) if (vram_we) begin
    wa.push_back(vram_waddr);
    wd.push_back(vram_wdata);
    wc.push_back(cyc);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; info_e = 1'b0;
    @(negedge clk); reset = 1'b0;
    clear_log();
  endtask

  // drives one word per cycle starting at the next negedge; returns its push cycle
  task automatic push_words(input logic [15:0] w[$], output int p);
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk);
      if (i == 0) p = cyc;
      info = w[i]; info_e = 1'b1;
    end
    @(negedge clk); info_e = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin @(negedge clk); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int p;
    logic [15:0] w[$];
    logic [15:0] exp_d[$];
    logic [AW-1:0] exp_a[$];

    // reset state
    @(negedge clk);
    chk("rst_we", {31'd0, vram_we}, 0);
    chk("rst_addr", {29'd0, vram_waddr}, 0);
    chk("rst_data", {16'd0, vram_wdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    @(negedge clk); reset = 1'b0;

    // single word 0x20A5
    clear_log();
    w = '{16'h20A5};
    @(negedge clk); p = cyc; info = w[0]; info_e = 1'b1;
    @(negedge clk); info_e = 1'b0;
    chk("single_busy_up", {31'd0, busy}, 1);
    wait_idle("single_idle", 20);
    chk("single_n", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("single_a0", {29'd0, wa[0]}, 0);
      chk("single_d0", {16'd0, wd[0]}, 16'h2041);
      chk("single_t0", wc[0], p + 2);
      chk("single_a1", {29'd0, wa[1]}, 1);
      chk("single_d1", {16'd0, wd[1]}, 16'h2035);
      chk("single_t1", wc[1], p + 3);
    end

    // back-to-back burst
    do_reset();
    w = '{16'h4012, 16'h40FF, 16'h2000};
    push_words(w, p);
    wait_idle("burst_idle", 30);
    exp_d = '{16'h4031, 16'h4032, 16'h4046, 16'h4046, 16'h2030, 16'h2030};
    chk("burst_n", wa.size(), 6);
    if (wa.size() == 6) begin
      chk("burst_t0", wc[0], p + 2);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("burst_a%0d", i), {29'd0, wa[i]}, i);
        chk($sformatf("burst_d%0d", i), {16'd0, wd[i]}, {16'd0, exp_d[i]});
        chk($sformatf("burst_t%0d", i), wc[i], wc[0] + i);
      end
    end

    // newline and row wrap
    do_reset();
    w = '{16'h2001, 16'h000A, 16'h2002, 16'h2002, 16'h2002};
    push_words(w, p);
    wait_idle("nl_idle", 40);
    exp_a = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    exp_d = '{16'h2030, 16'h2031, 16'h2030, 16'h2032, 16'h2030, 16'h2032, 16'h2030, 16'h2032};
    chk("nl_n", wa.size(), 8);
    if (wa.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("nl_a%0d", i), {29'd0, wa[i]}, {29'd0, exp_a[i]});
        chk($sformatf("nl_d%0d", i), {16'd0, wd[i]}, {16'd0, exp_d[i]});
      end
    chk("nl_ovf", {31'd0, overflow}, 0);

    // clear with a push arriving mid-clear
    do_reset();
    w = '{16'h2001};
    push_words(w, p);
    wait_idle("clr_fill_idle", 20);
    clear_log();
    w = '{16'h000C};
    push_words(w, p);
    repeat (2) @(negedge clk);
    w = '{16'h2077};
    push_words(w, p);
    wait_idle("clr_idle", 60);
    chk("clr_n", wa.size(), 10);
    if (wa.size() == 10) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("clr_a%0d", i), {29'd0, wa[i]}, i);
        chk($sformatf("clr_d%0d", i), {16'd0, wd[i]}, 16'h0020);
      end
      chk("clr_post_a0", {29'd0, wa[8]}, 0);
      chk("clr_post_d0", {16'd0, wd[8]}, 16'h2037);
      chk("clr_post_a1", {29'd0, wa[9]}, 1);
      chk("clr_post_d1", {16'd0, wd[9]}, 16'h2037);
    end

    // overflow: six pushes during a clear into a 4-deep FIFO
    do_reset();
    w = '{16'h000C, 16'h1031, 16'h1032, 16'h1033, 16'h1034, 16'h1035, 16'h1036};
    push_words(w, p);
    chk("ovf_set", {31'd0, overflow}, 1);
    wait_idle("ovf_idle", 80);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", {31'd0, overflow}, 1);
    chk("ovf_n", wa.size(), 16);
    if (wa.size() == 16)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("ovf_a%0d", 2*k), {29'd0, wa[8+2*k]}, 2*k);
        chk($sformatf("ovf_hi%0d", k), {16'd0, wd[8+2*k]}, 16'h1033);
        chk($sformatf("ovf_lo%0d", k), {16'd0, wd[9+2*k]}, 16'h1031 + k);
      end

    // asynchronous reset in the middle of a clear
    do_reset();
    w = '{16'h000C};
    push_words(w, p);
    repeat (2) @(negedge clk);
    chk("mid_clear_active", {31'd0, vram_we}, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, vram_we}, 0);
    chk("mid_rst_addr", {29'd0, vram_waddr}, 0);
    chk("mid_rst_data", {16'd0, vram_wdata}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk); reset = 1'b0;
    clear_log();
    w = '{16'h2045};
    push_words(w, p);
    wait_idle("mid_idle", 20);
    chk("mid_n", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("mid_a0", {29'd0, wa[0]}, 0);
      chk("mid_d0", {16'd0, wd[0]}, 16'h2034);
      chk("mid_d1", {16'd0, wd[1]}, 16'h2035);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
